// File: rtl/ahb_slave_arbiter_pkg.sv
// Shared AHB types and helpers for the interconnect arbiters.
// Pure declarations: no latency or backpressure of its own.
package ahb_slave_arbiter_pkg;

    localparam int NO_OF_MASTERS = 4;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BURST,
        ARB_LOCKED
    } arb_state_e;

    // Zero means undefined length (INCR).
    function automatic logic [4:0] burst_len(input hburst_e hburst);
        case (hburst)
            HBURST_SINGLE:               return 5'd1;
            HBURST_WRAP4,  HBURST_INCR4:  return 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  return 5'd8;
            HBURST_WRAP16, HBURST_INCR16: return 5'd16;
            default:                     return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Round-robin picker: first set request at or after i_rr_ptr, one-hot plus index.
// Purely combinational (zero latency); no backpressure.
module ahb_rr_picker #(
    parameter int NO_OF_MASTERS = 4,
    parameter int MID_W         = $clog2(NO_OF_MASTERS)
) (
    input  logic [NO_OF_MASTERS-1:0] i_req,
    input  logic [MID_W-1:0]         i_rr_ptr,
    output logic [NO_OF_MASTERS-1:0] o_pick,
    output logic [MID_W-1:0]         o_pick_idx,
    output logic                     o_pick_vld
);

    logic [MID_W-1:0] w_idx;

    always_comb begin
        o_pick     = '0;
        o_pick_idx = '0;
        o_pick_vld = 1'b0;
        w_idx      = '0;
        for (int i = 0; i < NO_OF_MASTERS; i++) begin
            w_idx = MID_W'((int'(i_rr_ptr) + i) % NO_OF_MASTERS);
            if (!o_pick_vld && i_req[w_idx]) begin
                o_pick_vld    = 1'b1;
                o_pick[w_idx] = 1'b1;
                o_pick_idx    = w_idx;
            end
        end
    end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB address-phase arbiter with round-robin, burst/lock hold and data-owner tracking.
// Grant registered (1 cycle), data owner 1 cycle after acceptance; all state frozen while hready=0.
module ahb_slave_arbiter #(
    parameter int NO_OF_MASTERS = ahb_slave_arbiter_pkg::NO_OF_MASTERS,
    parameter int MID_W         = $clog2(NO_OF_MASTERS)
) (
    input  logic                       hclk,
    input  logic                       hresetn,
    input  logic [NO_OF_MASTERS-1:0]   m_req,
    input  logic [2*NO_OF_MASTERS-1:0] m_htrans,
    input  logic [3*NO_OF_MASTERS-1:0] m_hburst,
    input  logic [NO_OF_MASTERS-1:0]   m_hmastlock,
    input  logic                       hready,
    output logic [NO_OF_MASTERS-1:0]   hgrant,
    output logic [MID_W-1:0]           addr_owner,
    output logic                       addr_owner_valid,
    output logic [MID_W-1:0]           data_owner,
    output logic                       data_owner_valid
);

    import ahb_slave_arbiter_pkg::*;

    arb_state_e               r_state, w_state_nxt;
    logic [NO_OF_MASTERS-1:0] r_hgrant, w_hgrant_nxt;
    logic [MID_W-1:0]         r_addr_owner, w_addr_owner_nxt;
    logic [MID_W-1:0]         r_rr_ptr, w_rr_ptr_nxt;
    logic [MID_W-1:0]         r_data_owner, w_data_owner_nxt;
    logic                     r_data_vld, w_data_vld_nxt;
    logic [4:0]               r_beat_cnt, w_beat_cnt_nxt;
    logic                     r_started, w_started_nxt;
    logic                     r_incr, w_incr_nxt;

    logic [1:0]               w_trans [NO_OF_MASTERS];
    logic [2:0]               w_burst [NO_OF_MASTERS];
    htrans_e                  w_own_trans;
    hburst_e                  w_own_burst;
    logic                     w_own_req;
    logic                     w_own_lock;
    logic [4:0]               w_len;
    logic                     w_accept;
    logic                     w_release;

    logic [NO_OF_MASTERS-1:0] w_pick;
    logic [MID_W-1:0]         w_pick_idx;
    logic                     w_pick_vld;

    for (genvar g = 0; g < NO_OF_MASTERS; g++) begin : g_unpack
        assign w_trans[g] = m_htrans[2*g +: 2];
        assign w_burst[g] = m_hburst[3*g +: 3];
    end

    assign w_own_trans = htrans_e'(w_trans[r_addr_owner]);
    assign w_own_burst = hburst_e'(w_burst[r_addr_owner]);
    assign w_own_req   = m_req[r_addr_owner];
    assign w_own_lock  = m_hmastlock[r_addr_owner];
    assign w_len       = burst_len(w_own_burst);
    assign w_accept    = (r_state != ARB_IDLE) &&
                         (w_own_trans == HTRANS_NONSEQ || w_own_trans == HTRANS_SEQ);

    ahb_rr_picker #(
        .NO_OF_MASTERS (NO_OF_MASTERS),
        .MID_W         (MID_W)
    ) u_picker (
        .i_req      (m_req),
        .i_rr_ptr   (r_rr_ptr),
        .o_pick     (w_pick),
        .o_pick_idx (w_pick_idx),
        .o_pick_vld (w_pick_vld)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_hgrant_nxt     = r_hgrant;
        w_addr_owner_nxt = r_addr_owner;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_beat_cnt_nxt   = r_beat_cnt;
        w_started_nxt    = r_started;
        w_incr_nxt       = r_incr;
        w_data_owner_nxt = r_data_owner;
        w_data_vld_nxt   = 1'b0;
        w_release        = 1'b0;

        if (w_accept) begin
            w_data_owner_nxt = r_addr_owner;
            w_data_vld_nxt   = 1'b1;
        end

        case (r_state)
            ARB_IDLE: w_release = 1'b1;
            ARB_BURST: begin
                // A NONSEQ after the burst has started is either early termination or a new burst.
                if (w_own_trans == HTRANS_IDLE || !w_own_req)
                    w_release = 1'b1;
                else if (w_own_trans == HTRANS_NONSEQ)
                    w_release = r_started || (w_len == 5'd1);
                else if (w_own_trans == HTRANS_SEQ)
                    w_release = !r_incr && (r_beat_cnt <= 5'd1);
            end
            ARB_LOCKED: w_release = !w_own_lock && (w_own_trans == HTRANS_IDLE);
            default:    w_release = 1'b1;
        endcase

        if (r_state != ARB_IDLE) begin
            if (w_own_trans == HTRANS_NONSEQ) begin
                w_beat_cnt_nxt = (w_len == 5'd0) ? 5'd0 : w_len - 5'd1;
                w_incr_nxt     = (w_len == 5'd0);
                w_started_nxt  = 1'b1;
            end else if (w_own_trans == HTRANS_SEQ) begin
                w_beat_cnt_nxt = (r_beat_cnt == 5'd0) ? 5'd0 : r_beat_cnt - 5'd1;
            end
        end

        if (w_release) begin
            w_started_nxt  = 1'b0;
            w_beat_cnt_nxt = 5'd0;
            w_incr_nxt     = 1'b0;
            if (w_pick_vld) begin
                w_hgrant_nxt     = w_pick;
                w_addr_owner_nxt = w_pick_idx;
                w_rr_ptr_nxt     = (w_pick_idx == MID_W'(NO_OF_MASTERS-1)) ? '0 : w_pick_idx + 1'b1;
                w_state_nxt      = m_hmastlock[w_pick_idx] ? ARB_LOCKED : ARB_BURST;
            end else begin
                w_hgrant_nxt = '0;
                w_state_nxt  = ARB_IDLE;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state      <= ARB_IDLE;
            r_hgrant     <= '0;
            r_addr_owner <= '0;
            r_rr_ptr     <= '0;
            r_data_owner <= '0;
            r_data_vld   <= 1'b0;
            r_beat_cnt   <= 5'd0;
            r_started    <= 1'b0;
            r_incr       <= 1'b0;
        end else if (hready) begin
            r_state      <= w_state_nxt;
            r_hgrant     <= w_hgrant_nxt;
            r_addr_owner <= w_addr_owner_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_data_owner <= w_data_owner_nxt;
            r_data_vld   <= w_data_vld_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
            r_started    <= w_started_nxt;
            r_incr       <= w_incr_nxt;
        end
    end

    assign hgrant           = r_hgrant;
    assign addr_owner       = r_addr_owner;
    assign addr_owner_valid = |r_hgrant;
    assign data_owner       = r_data_owner;
    assign data_owner_valid = r_data_vld;

endmodule

// File: doc/ahb_slave_arbiter.md
Name: ahb_slave_arbiter

Overview:
Per-slave AHB arbiter; one instance per slave port in the multi-master interconnect.
It takes decoded requests from all masters targeting its slave and grants the address phase to exactly one master, using round-robin priority.
The grant is held for the whole of a fixed-length burst, an undefined INCR burst, or a locked sequence.
It also tracks the data-phase owner, which the interconnect uses for hwdata/hrdata/hresp steering and for per-master hready.

Parameters:
NO_OF_MASTERS, 4, number of requesting masters (≥2)
MID_W, $clog2(NO_OF_MASTERS), width of master index

Ports:
hclk  input  1  clock
hresetn  input  1  reset
m_req  input  NO_OF_MASTERS  master m's haddr decodes to this slave and m_htrans[m]!=IDLE
m_htrans  input  2*NO_OF_MASTERS  packed htrans per master (master m at [2m+1:2m])
m_hburst  input  3*NO_OF_MASTERS  packed hburst per master
m_hmastlock  input  NO_OF_MASTERS  hmastlock per master
hready  input  1  slave hreadyout
hgrant  output  NO_OF_MASTERS  one-hot address-phase grant, registered
addr_owner  output  MID_W  index of granted master
addr_owner_valid  output  1  hgrant non-zero
data_owner  output  MID_W  master whose transfer is in data phase
data_owner_valid  output  1  a data phase is active

Behaviour:
- Interface: one clock hclk; reset hresetn is asynchronous and active-low.
- Reset (asynchronous, any cycle, including mid-burst): hgrant=0, addr_owner=0, addr_owner_valid=0, data_owner=0, data_owner_valid=0, rr_ptr=0, beat_cnt=0, state=IDLE.
- All state updates occur at posedge hclk only when hready=1. When hready=0, every register holds.
- "Owner transfer accepted" means hready=1 and the owner's htrans is NONSEQ or SEQ.
- Data-phase tracking:
  - Accepted transfer: data_owner<=addr_owner, data_owner_valid<=1.
  - Owner htrans IDLE or BUSY with hready=1: data_owner_valid<=0.
  - Latency from address acceptance to data_owner is exactly 1 cycle.
- Round-robin pick: search m_req starting at rr_ptr, incrementing mod NO_OF_MASTERS; take the first set bit. When a new grant goes to m, rr_ptr<=(m+1) mod NO_OF_MASTERS.
- Beat length from hburst at NONSEQ:
  - SINGLE=1; WRAP4/INCR4=4; WRAP8/INCR8=8; WRAP16/INCR16=16.
  - INCR=0, meaning undefined length.
  - beat_cnt is 5 bits, loaded with len-1. It decrements on each accepted SEQ and saturates at 0.
- State machine:
  - IDLE: no grant.
    - Any m_req → grant pick, go to BURST (or LOCKED if the picked master has hmastlock=1).
  - BURST:
    - Owner NONSEQ accepted → load beat_cnt.
    - Owner BUSY → hold grant, no decrement.
    - Release when any of these holds:
      - a fixed burst's last beat is accepted (beat_cnt==0 and transfer accepted);
      - an INCR burst's owner htrans is IDLE or NONSEQ to a different slave, i.e. m_req[owner]=0;
      - the owner htrans is IDLE.
  - LOCKED: grant held regardless of burst end. Release only on an hready=1 cycle where the owner has hmastlock=0 and htrans=IDLE.
- Release with other requests pending: in the same edge, grant the next RR pick (no dead cycle) and enter BURST or LOCKED. Release with none pending: go to IDLE and clear hgrant.
- Release with the owner itself still requesting (new NONSEQ): RR proceeds normally. The owner regains the grant only if no other master is requesting.
- Early burst termination (owner issues NONSEQ mid-burst to the same slave): treated as a release point.
- Requests from non-owners never alter hgrant until a release point.
- hgrant is always one-hot or zero; addr_owner_valid equals |hgrant.

Decomposition:
- AhbGlobalPackage holds:
  - NO_OF_MASTERS;
  - htrans enum (IDLE/BUSY/NONSEQ/SEQ);
  - hburst enum;
  - arb_state_e {ARB_IDLE, ARB_BURST, ARB_LOCKED};
  - function burst_len(hburst) returning beat count.
- One sub-module, ahb_rr_picker: combinational, taking req vector and rr_ptr and producing a one-hot pick plus a valid flag. It is reused by the interconnect's other arbiters.

Test Plan:
All scenarios use NO_OF_MASTERS=4.
- Reset mid-burst: M1 owns INCR8 at beat 3, assert hresetn=0 → hgrant=0000, both valids 0 immediately (no clock edge), rr_ptr=0 after release.
- Simultaneous requests: M0–M3 all request SINGLE, hready=1 continuously → grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles; data_owner follows one cycle later.
- Fixed burst hold: M2 issues INCR4 with BUSY inserted after beat 2 while M0 requests → hgrant stays 0100 for 5 hready cycles, switches to 0001 on the edge that accepts beat 4.
- Wait states: M1 SINGLE with slave hready=0 for 3 cycles while M3 requests → hgrant and data_owner frozen; M3 granted on the first hready=1 edge.
- Locked sequence: M3 with hmastlock=1 does two INCR4 bursts then IDLE while M0 requests → hgrant=1000 throughout; M0 granted only on the edge where M3 has htrans=IDLE and hmastlock=0.
- Undefined INCR: M0 INCR for 10 beats, then NONSEQ to another slave (m_req[0]=0) while M1 requests → M1 granted on that edge; no dead cycle.
